// File: rtl/bi_pad_ctrl_pkg.sv
// Shared types and constants for the bidirectional pad controller.
package bi_pad_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IN     = 2'd0,
    ST_TO_OUT = 2'd1,
    ST_OUT    = 2'd2,
    ST_TO_IN  = 2'd3
  } pad_state_e;

  localparam logic [1:0] PULL_NONE = 2'b00;
  localparam logic [1:0] PULL_DN   = 2'b01;
  localparam logic [1:0] PULL_UP   = 2'b10;
  localparam logic [1:0] PULL_KEEP = 2'b11;

  // Bits needed to hold a count of 0..max_val (turnaround uses max_val = TURN_CYC).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bi_pad_in_filter.sv
// Pad input path: synchroniser, qualification, edge pulses. The glitch filter
// is compiled in only when BI_PAD_CTRL_GLITCH_FILTER_EN is defined.
module bi_pad_in_filter
  import bi_pad_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_y_i,
  input  logic in_mode_i,
  output logic in_data_o,
  output logic in_valid_o,
  output logic in_rise_o,
  output logic in_fall_o
);

`ifdef BI_PAD_CTRL_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  // Without the filter the in_data flop is itself the last synchroniser stage.
  localparam int CHAIN = FILT_EN ? SYNC_STAGES : SYNC_STAGES - 1;
  localparam int QUAL  = FILT_EN ? SYNC_STAGES + FILT_CYC : SYNC_STAGES;
  localparam int QCW   = cnt_width(QUAL - 1);
  localparam logic [QCW-1:0] QUAL_LAST = QCW'(QUAL - 1);

  logic [CHAIN-1:0] sync_q, sync_d;
  logic [QCW-1:0]   qcnt_q, qcnt_d;
  logic data_q, data_d, valid_q, valid_d;
  logic rise_q, rise_d, fall_q, fall_d;
  logic sample;

`ifdef BI_PAD_CTRL_GLITCH_FILTER_EN
  localparam int FCW = cnt_width(FILT_CYC - 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_CYC - 1);
  logic [FCW-1:0] fcnt_q, fcnt_d;
`endif

  assign sample = sync_q[CHAIN-1];

  always_comb begin
    sync_d[0] = pad_y_i;
    for (int i = 1; i < CHAIN; i++) sync_d[i] = sync_q[i-1];
  end

  always_comb begin
    valid_d = in_mode_i && (qcnt_q == QUAL_LAST);
    if (!in_mode_i)               qcnt_d = '0;
    else if (qcnt_q == QUAL_LAST) qcnt_d = qcnt_q;
    else                          qcnt_d = qcnt_q + 1'b1;

    data_d = data_q;
`ifdef BI_PAD_CTRL_GLITCH_FILTER_EN
    // Counter saturates while unqualified so a settled level lands as soon as in_valid rises.
    fcnt_d = '0;
    if (sample != data_q) begin
      if (fcnt_q != FILT_LAST) fcnt_d = fcnt_q + 1'b1;
      else if (valid_d)        data_d = sample;
      else                     fcnt_d = fcnt_q;
    end
`else
    if (valid_d) data_d = sample;
`endif

    rise_d = valid_d & valid_q &  data_d & ~data_q;
    fall_d = valid_d & valid_q & ~data_d &  data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      qcnt_q  <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`ifdef BI_PAD_CTRL_GLITCH_FILTER_EN
      fcnt_q  <= '0;
`endif
    end else begin
      sync_q  <= sync_d;
      qcnt_q  <= qcnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`ifdef BI_PAD_CTRL_GLITCH_FILTER_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end

  assign in_data_o  = data_q;
  assign in_valid_o = valid_q;
  assign in_rise_o  = rise_q;
  assign in_fall_o  = fall_q;

endmodule

// File: rtl/bi_pad_ctrl.sv
// Bidirectional pad controller: direction turnaround FSM and registered pad controls.
// Input deglitching depends on BI_PAD_CTRL_GLITCH_FILTER_EN (see bi_pad_in_filter).
//
// state     | meaning
// ST_IN     | input mode, pulls per pull_mode, input path may qualify
// ST_TO_OUT | turnaround: driver off, pulls off, input buffer off
// ST_OUT    | driving pad_a, pulls off, input buffer off
// ST_TO_IN  | turnaround: driver off, pulls off, input buffer on
module bi_pad_ctrl
  import bi_pad_ctrl_pkg::*;
#(
  parameter int TURN_CYC    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       out_data,
  input  logic       out_en_req,
  input  logic [1:0] pull_mode,
  input  logic [1:0] drive_sel,
  input  logic       slew_sel,
  input  logic       schmitt_sel,
  output logic       pad_a,
  output logic       pad_oe,
  output logic       pad_ie,
  output logic       pad_pu,
  output logic       pad_pd,
  output logic       pad_pdrv0,
  output logic       pad_pdrv1,
  output logic       pad_sl,
  output logic       pad_cs,
  input  logic       pad_y,
  output logic       in_data,
  output logic       in_valid,
  output logic       in_rise,
  output logic       in_fall,
  output logic       dir_out,
  output logic       busy
);

  localparam int TCW = cnt_width(TURN_CYC);
  localparam logic [TCW-1:0] TURN_LOAD = TCW'(TURN_CYC - 1);

  pad_state_e     state_q, state_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic a_q, a_d, oe_q, oe_d, ie_q, ie_d, pu_q, pu_d, pd_q, pd_d;
  logic dir_q, dir_d, busy_q, busy_d, sl_q, cs_q;
  logic [1:0] pdrv_q;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ST_IN: if (out_en_req) begin
        state_d = ST_TO_OUT;
        tcnt_d  = TURN_LOAD;
      end
      ST_TO_OUT: if (tcnt_q == '0) state_d = ST_OUT;
                 else              tcnt_d  = tcnt_q - 1'b1;
      ST_OUT: if (!out_en_req) begin
        state_d = ST_TO_IN;
        tcnt_d  = TURN_LOAD;
      end
      ST_TO_IN: if (tcnt_q == '0) state_d = ST_IN;
                else              tcnt_d  = tcnt_q - 1'b1;
      default: state_d = ST_IN;
    endcase

    // Controls are registered from the next state so they change on the transition edge.
    oe_d   = (state_d == ST_OUT);
    a_d    = oe_d & out_data;
    ie_d   = (state_d == ST_IN) || (state_d == ST_TO_IN);
    dir_d  = oe_d;
    busy_d = (state_d == ST_TO_OUT) || (state_d == ST_TO_IN);
    pu_d   = 1'b0;
    pd_d   = 1'b0;
    if (state_d == ST_IN) begin
      case (pull_mode)
        PULL_DN:   pd_d = 1'b1;
        PULL_UP:   pu_d = 1'b1;
        PULL_KEEP: begin
          pu_d = in_data;
          pd_d = ~in_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IN;
      tcnt_q  <= '0;
      a_q     <= 1'b0;
      oe_q    <= 1'b0;
      ie_q    <= 1'b1;
      pu_q    <= 1'b0;
      pd_q    <= 1'b0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      pdrv_q  <= 2'b00;
      sl_q    <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      a_q     <= a_d;
      oe_q    <= oe_d;
      ie_q    <= ie_d;
      pu_q    <= pu_d;
      pd_q    <= pd_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      pdrv_q  <= drive_sel;
      sl_q    <= slew_sel;
      cs_q    <= schmitt_sel;
    end
  end

  bi_pad_in_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYC    (FILT_CYC)
  ) u_in_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .pad_y_i    (pad_y),
    .in_mode_i  (state_d == ST_IN),
    .in_data_o  (in_data),
    .in_valid_o (in_valid),
    .in_rise_o  (in_rise),
    .in_fall_o  (in_fall)
  );

  assign pad_a     = a_q;
  assign pad_oe    = oe_q;
  assign pad_ie    = ie_q;
  assign pad_pu    = pu_q;
  assign pad_pd    = pd_q;
  assign pad_pdrv0 = pdrv_q[0];
  assign pad_pdrv1 = pdrv_q[1];
  assign pad_sl    = sl_q;
  assign pad_cs    = cs_q;
  assign dir_out   = dir_q;
  assign busy      = busy_q;

endmodule

// File: doc/bi_pad_ctrl.md
Name: bi_pad_ctrl

Overview:
Core-side controller that sits directly upstream of the bidirectional pad cell. It drives the pad controls (A, OE, IE, PU, PD, PDRV0/1, SL, CS) and consumes the pad's Y output. It sequences direction turnaround so the output driver never fights pulls or an external driver. It also synchronises, and optionally deglitches, the pad input, producing qualified level and edge outputs for core logic.

Parameters:
TURN_CYC, 2, idle cycles in each turnaround state (≥1)
SYNC_STAGES, 2, flops in the pad_y synchroniser (≥2)
FILT_CYC, 4, consecutive equal samples required by the glitch filter (≥2)

Ports:
clk  in  1  core clock
rst_n  in  1  reset, synchronous, active-low
out_data  in  1  value to drive when in output mode
out_en_req  in  1  1 = request output mode, 0 = request input mode
pull_mode  in  2  00 none, 01 pull-down, 10 pull-up, 11 bus keeper
drive_sel  in  2  drive strength; maps to {pad_pdrv1, pad_pdrv0}
slew_sel  in  1  maps to pad_sl
schmitt_sel  in  1  maps to pad_cs
pad_a, pad_oe, pad_ie, pad_pu, pad_pd, pad_pdrv0, pad_pdrv1, pad_sl, pad_cs  out  1 each  pad-cell controls
pad_y  in  1  pad-cell input data (asynchronous)
in_data  out  1  synchronised/filtered pad level
in_valid  out  1  in_data is qualified
in_rise, in_fall  out  1 each  single-cycle edge pulses on in_data
dir_out  out  1  1 only in state OUT
busy  out  1  1 in either turnaround state

Behaviour:
- All outputs are registered. Reset values: state IN; pad_a=0; pad_oe=0; pad_ie=1; pad_pu=0; pad_pd=0; pdrv=00; pad_sl=0; pad_cs=0; in_data=0; in_valid=0; edge pulses=0; dir_out=0; busy=0. All synchroniser/filter flops clear to 0.
- FSM states: IN, TO_OUT, OUT, TO_IN. A turnaround counter loads TURN_CYC-1 on entry to a turnaround state.
- IN: pad_oe=0, pad_ie=1, pulls per pull_mode. In keeper mode, pad_pu=in_data and pad_pd=~in_data.
  - On out_en_req=1: go to TO_OUT. pulls→0 and in_valid→0 on the same edge.
- TO_OUT: pad_oe=0, pulls=0, pad_ie=0. Stay TURN_CYC cycles, then go to OUT.
- OUT: pad_oe=1, pad_a=out_data registered each cycle (1-cycle latency), pad_ie=0, pulls=0.
  - On out_en_req=0: go to TO_IN. pad_oe→0 on the same edge.
- TO_IN: pad_oe=0, pulls=0, pad_ie=1. Stay TURN_CYC cycles, then go to IN, where pulls are restored.
- Turnarounds are never aborted. out_en_req is re-evaluated only on arrival in IN or OUT, so a request toggled during a turnaround causes an immediate reverse turnaround afterwards.
- pad_pu and pad_pd are never both 1, and pad_oe=1 implies pulls=0 (assertion targets).
- drive_sel, slew_sel and schmitt_sel are registered every cycle, independent of state.
- Input path:
  - pad_y passes through SYNC_STAGES flops; the chain runs in all states.
  - in_valid rises after pad_ie has been 1 for SYNC_STAGES consecutive cycles while in IN, plus FILT_CYC if the filter is compiled in. in_valid is 0 in all other states.
  - in_data holds its last value while in_valid=0.
  - in_rise/in_fall pulse for one cycle when in_data changes while in_valid=1. No pulse is generated on the in_valid 0→1 transition.
- Reset asserted mid-operation: on that edge, pad_oe→0 and all outputs return to reset values.

Optional Feature:
BI_PAD_CTRL_GLITCH_FILTER_EN
- Defined: a saturating counter compares the synchroniser output with in_data. in_data updates only after FILT_CYC consecutive cycles of a differing sample; any matching sample clears the counter. pad_y→in_data latency is SYNC_STAGES+FILT_CYC cycles.
- Undefined: in_data equals the synchroniser output, with latency SYNC_STAGES. No counter logic is present.

Decomposition:
- Package bi_pad_ctrl_pkg holds:
  - state enum (IN, TO_OUT, OUT, TO_IN)
  - pull_mode constants (PULL_NONE, PULL_DN, PULL_UP, PULL_KEEP)
  - a function for turnaround counter width, $clog2(TURN_CYC+1)
- One sub-module, bi_pad_in_filter: synchroniser, optional glitch filter, edge detection and in_valid qualification. The FSM and pad control outputs stay in the top module.

Test Plan:
- Reset release, pull_mode=10, pad_y=1 → pad_pu=1, pad_pd=0, pad_oe=0; in_valid=1 after 2 cycles (6 with filter); in_data=1; no edge pulse.
- out_en_req 0→1, TURN_CYC=2 → pulls=0 at the next edge; pad_oe=1 exactly 3 cycles after the request edge; busy high for 2 cycles; pad_a follows out_data with 1-cycle lag.
- In OUT, out_en_req→0 → pad_oe=0 on the next edge; pulls restored after 2 cycles in TO_IN; in_valid returns after SYNC_STAGES(+FILT_CYC).
- Filter build with FILT_CYC=4: pad_y glitch high for 3 cycles → no in_data change and no in_rise; a 4-cycle high → in_data=1 and one in_rise pulse.
- pull_mode=11, pad_y driven 0 then released → pad_pd=1 and holds; after driving 1 and releasing → pad_pu=1.
- Reset asserted while in OUT → pad_oe=0, pad_ie=1, state IN on the same edge; out_en_req toggled mid-TO_OUT → OUT reached, then an immediate TO_IN.
